// File: rtl/ahb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package ahb_bridge_pkg;

  // AHB transfer types
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // AHB response codes
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Response FSM states; ERR1/ERR2 are the two cycles of an AHB ERROR response
  typedef enum logic [1:0] {
    OKAY = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } resp_state_t;

  // Default bridge address window
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SPAN  = 32'h0400_0000;

  // Only byte, halfword and word transfers reach the APB side
  function automatic logic size_ok(input logic [2:0] hsize);
    return (hsize <= 3'd2);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decode: peripheral one-hot select, window hit and
// natural alignment of the access. Shared with the bridge's address checker,
// so it carries no transfer qualification of its own.
module ahb_addr_decode
  import ahb_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          NUM_SLV   = 3,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] SLV_SPAN  = DEF_SLV_SPAN
) (
  input  logic [ADDR_W-1:0]  haddr_i,
  input  logic [2:0]         hsize_i,
  output logic [NUM_SLV-1:0] tempselx_o,
  output logic               in_range_o,
  output logic               aligned_o
);

  // Window arithmetic is done in 64 bits so the end of the window cannot wrap
  localparam logic [63:0] BASE64  = 64'(BASE_ADDR);
  localparam logic [63:0] SPAN64  = 64'(SLV_SPAN);
  localparam logic [63:0] WIN_END = BASE64 + (64'(NUM_SLV) * SPAN64);

  logic [63:0] addr_w;
  logic [63:0] offset;

  // Window hit and per-region select
  always_comb begin
    tempselx_o = '0;
    addr_w     = 64'(haddr_i);
    offset     = addr_w - BASE64;
    in_range_o = (addr_w >= BASE64) && (addr_w < WIN_END);
    for (int i = 0; i < NUM_SLV; i++) begin
      tempselx_o[i] = in_range_o &&
                      (offset >= (64'(i) * SPAN64)) &&
                      (offset <  (64'(i + 1) * SPAN64));
    end
  end

  // Natural alignment; sizes above a word are never considered aligned
  always_comb begin
    case (hsize_i)
      3'd0:    aligned_o = 1'b1;
      3'd1:    aligned_o = ~haddr_i[0];
      3'd2:    aligned_o = (haddr_i[1:0] == 2'b00);
      default: aligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb_slave_frontend.sv
// AHB slave front-end of the AHB-to-APB bridge: qualifies transfers, decodes
// the peripheral, pipelines address/data/direction for the APB FSM, returns
// read data and drives Hreadyout/Hresp including the two-cycle ERROR response.
//
// Handshake: an address phase is sampled on a rising edge only when
// Hreadyin=1 (bus-level HREADY); with Hreadyin=0 every pipeline stage holds.
// valid marks a legal NONSEQ/SEQ transfer that the APB FSM should act on in
// this cycle; bridge_ready=0 stretches the data phase through Hreadyout.
module ahb_slave_frontend
  import ahb_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          NUM_SLV   = 3,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] SLV_SPAN  = DEF_SLV_SPAN
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic [1:0]         Htrans,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [2:0]         Hsize,
  input  logic [2:0]         Hburst,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  input  logic               bridge_ready,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               prdata_valid,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [ADDR_W-1:0]  haddr1,
  output logic [ADDR_W-1:0]  haddr2,
  output logic [DATA_W-1:0]  hwdata1,
  output logic [DATA_W-1:0]  hwdata2,
  output logic               hwrite_reg,
  output logic               hwrite_reg1,
  output logic [2:0]         hsize_reg,
  output logic [2:0]         hburst_reg,
  output logic [1:0]         state_dbg
);

  htrans_t             htrans;
  logic                active;
  logic                legal;
  logic                illegal;
  logic                in_range;
  logic                aligned;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                hready_int;
  resp_state_t         state_q;
  resp_state_t         state_d;

  ahb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN)
  ) u_decode (
    .haddr_i    (Haddr),
    .hsize_i    (Hsize),
    .tempselx_o (dec_sel),
    .in_range_o (in_range),
    .aligned_o  (aligned)
  );

  // Transfer qualification: IDLE and BUSY never count, nor does an address
  // phase presented while the bus is stalled.
  always_comb begin
    htrans  = htrans_t'(Htrans);
    active  = Hreadyin && ((htrans == NONSEQ) || (htrans == SEQ));
    legal   = active && in_range && aligned && size_ok(Hsize);
    illegal = active && !legal;
  end

  // Downstream strobes; a legal transfer arriving during ERR2 is dropped and
  // must be re-issued by the master.
  always_comb begin
    valid    = Hresetn && legal && (state_q == OKAY);
    tempselx = (Hresetn && active) ? dec_sel : '0;
  end

  // Slave response; Hreadyout is held high while in reset
  always_comb begin
    case (state_q)
      OKAY:    hready_int = bridge_ready;
      ERR1:    hready_int = 1'b0;
      ERR2:    hready_int = 1'b1;
      default: hready_int = 1'b1;
    endcase
    Hreadyout = hready_int || !Hresetn;
    Hresp     = (state_q == OKAY) ? HRESP_OKAY : HRESP_ERROR;
    state_dbg = state_q;
  end

  // Response FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      OKAY: if (illegal && hready_int) state_d = ERR1;
      ERR1: state_d = ERR2;
      ERR2: state_d = illegal ? ERR1 : OKAY;
      default: state_d = OKAY;
    endcase
  end

  // Response FSM state register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= OKAY;
    else          state_q <= state_d;
  end

  // Two-stage address/data/direction pipeline, frozen while the bus stalls
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
      hsize_reg   <= '0;
      hburst_reg  <= '0;
    end else if (Hreadyin) begin
      haddr1      <= Haddr;
      haddr2      <= haddr1;
      hwdata1     <= Hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= Hwrite;
      hwrite_reg1 <= hwrite_reg;
      hsize_reg   <= Hsize;
      hburst_reg  <= Hburst;
    end
  end

  // Read data return register, loaded whenever the APB side has data
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)          Hrdata <= '0;
    else if (prdata_valid) Hrdata <= prdata;
  end

endmodule
